enemies_hit_collector: RTL
==========================

// Module: enemies_hit_collector
// PURPOSE
//  Consumer side of the per-pixel drawingRequest interface produced by the enemy/missile/player movers.
//  Each frame, records which enemies overlapped the missile and whether the player touched any enemy.
//  At startOfFrame, reports each hit enemy index to the game controller over a valid/ready stream.
//  Also pulses missile_hit and player_hit back to the movers and the game logic.
// PARAMETERS
//  N_ENEMIES   8   number of enemy drawingRequest inputs (1..32)
//  IDX_W       $clog2(N_ENEMIES) (min 1)   width of hit_index
// PORTS
//  clk            in   1          system clock (VGA pixel clock domain)
//  reset          in   1          synchronous, active-high reset
//  startOfFrame   in   1          1-cycle pulse, frame boundary
//  enemyDR        in   N_ENEMIES  drawingRequest of each enemy, bit i = enemy i
//  missileDR      in   1          missile drawingRequest
//  playerDR       in   1          player drawingRequest
//  hit_valid      out  1          hit_index holds a pending enemy hit
//  hit_ready      in   1          consumer accepts hit_index this cycle
//  hit_index      out  IDX_W      index of the hit enemy (lowest pending first)
//  missile_hit    out  1          1-cycle pulse: the finished frame had a missile/enemy overlap
//  player_hit     out  1          1-cycle pulse: the finished frame had a player/enemy overlap
//  frame_overrun  out  1          1-cycle pulse: a new snapshot arrived before pending hits drained
// BEHAVIOUR
//  Reset: all outputs 0; acc, pending, player_acc cleared; state IDLE. Reset mid-report drops all pending hits.
//  Accumulate (every non-reset cycle, all states):
//   - acc <= acc | (enemyDR & {N{missileDR}}).
//   - player_acc <= player_acc | (playerDR & |enemyDR).
//  Snapshot on startOfFrame:
//   - pending <= pending | acc_eff, where acc_eff includes this cycle's term.
//   - The startOfFrame-cycle pixel belongs to the finished frame.
//   - acc and player_acc clear to 0 in the same cycle.
//   - Next cycle: missile_hit = |acc_eff and player_hit = player_acc_eff, each high for exactly 1 cycle.
//   - If pending != 0 at snapshot, frame_overrun pulses next cycle. Old hits are kept (OR), never lost.
//  FSM: IDLE, REPORT.
//   - IDLE -> REPORT when pending becomes non-zero (cycle after snapshot).
//   - REPORT -> IDLE when the last pending bit is accepted and no snapshot occurs in the same cycle.
//  Stream (registered outputs):
//   - In REPORT: hit_valid=1 and hit_index = lowest set bit of pending.
//   - hit_index is stable while hit_valid && !hit_ready.
//   - Accept (hit_valid && hit_ready): clear that bit. The next index is presented the following cycle with no bubble.
//   - Snapshot coinciding with accept: the accepted bit clears, then new bits are ORed in.
//   - Latency: startOfFrame at cycle t -> first hit_valid at t+1.
//  Widths: index zero-extended to IDX_W; N_ENEMIES=1 gives IDX_W=1, index always 0.
// CONFIGURATION
//  HIT_STATS_EN defined:
//   - Adds output hit_total[15:0], reset 0.
//   - Increments by 1 per accepted hit; saturates at 16'hFFFF.
//  HIT_STATS_EN undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Package collision_pkg:
//   - N_ENEMIES_MAX=32.
//   - typedef enum logic {IDLE, REPORT} hit_state_t.
//   - typedef logic [N_ENEMIES_MAX-1:0] enemy_mask_t.
//  Sub-module lowest_set_index:
//   - Combinational priority encoder, param W.
//   - Outputs index of lowest set bit plus an any flag.
// TESTING
//  1. Reset: hold reset 3 cycles with random DR inputs -> all outputs 0. Then assert startOfFrame with no DR -> no pulses.
//  2. Single hit, N=8:
//     - Stimulus: missileDR&enemyDR[3] for 5 cycles, then startOfFrame at t.
//     - Response: missile_hit=1 at t+1. hit_valid=1, hit_index=3 at t+1. Held until hit_ready; valid=0 next cycle after accept.
//  3. Multi-hit ordering:
//     - Stimulus: hits on enemies 6, 1, 4; hit_ready tied 1.
//     - Response: indices 1, 4, 6 on consecutive cycles t+1..t+3, then valid=0.
//  4. Player collision: playerDR&enemyDR[0], no missile -> player_hit pulse at t+1; missile_hit=0; hit_valid=0.
//  5. Overrun:
//     - Stimulus: enemy 2 hit, hit_ready=0; next frame adds enemy 5.
//     - Response: frame_overrun pulse; pending={2,5}; release ready -> 2 then 5.
//  6. Boundary: overlap only on the startOfFrame cycle -> counted in the finished frame (hit_valid at t+1). Next frame reports nothing.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types for the enemy hit collection logic.
// Holds the reporting state encoding and the widest enemy mask supported.
package collision_pkg;

    localparam int N_ENEMIES_MAX = 32;

    typedef enum logic {IDLE, REPORT} hit_state_t;

    typedef logic [N_ENEMIES_MAX-1:0] enemy_mask_t;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder.
// Returns the index of the lowest set bit of vec_i and flags whether any bit is set.
module lowest_set_index #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] index_o,
    output logic          any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index_o = '0;
        any_o   = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                index_o = IW'(i);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemies_hit_collector.sv
// Collects per-frame missile/enemy and player/enemy overlaps from the pixel stream,
// then reports each hit enemy index over a valid/ready stream after the frame ends.
// Optional build macro: HIT_STATS_EN adds a saturating 16-bit accepted-hit counter (hit_total).
module enemies_hit_collector
    import collision_pkg::*;
#(
    parameter int N_ENEMIES = 8,
    parameter int IDX_W     = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic [N_ENEMIES-1:0] enemyDR,
    input  logic                 missileDR,
    input  logic                 playerDR,
    output logic                 hit_valid,
    input  logic                 hit_ready,
    output logic [IDX_W-1:0]     hit_index,
    output logic                 missile_hit,
    output logic                 player_hit,
    output logic                 frame_overrun
`ifdef HIT_STATS_EN
    ,
    output logic [15:0]          hit_total
`endif
);

    hit_state_t state_q, state_d;

    logic [N_ENEMIES-1:0] acc_q, acc_d;
    logic                 playerAcc_q, playerAcc_d;
    logic [N_ENEMIES-1:0] pending_q, pending_d;
    logic                 hitValid_q, hitValid_d;
    logic [IDX_W-1:0]     hitIndex_q, hitIndex_d;
    logic                 missileHit_q, missileHit_d;
    logic                 playerHit_q, playerHit_d;
    logic                 overrun_q, overrun_d;

    logic [N_ENEMIES-1:0] accEff;
    logic                 playerEff;
    logic                 accept;
    logic [N_ENEMIES-1:0] clearMask;
    logic [IDX_W-1:0]     nextIndex;
    logic                 pendingAny;

    // The startOfFrame pixel still belongs to the finishing frame, so the effective
    // accumulators include this cycle's overlap term.
    always_comb begin
        accEff    = acc_q | (enemyDR & {N_ENEMIES{missileDR}});
        playerEff = playerAcc_q | (playerDR & (|enemyDR));
        accept    = hitValid_q & hit_ready;
    end

    // One-hot mask of the index being accepted this cycle, removed before new hits merge in.
    always_comb begin
        clearMask = '0;
        if (accept) begin
            clearMask[hitIndex_q] = 1'b1;
        end
    end

    // Accumulators restart each frame; pending keeps old hits and ORs new ones in at the snapshot.
    always_comb begin
        acc_d        = accEff;
        playerAcc_d  = playerEff;
        pending_d    = pending_q & ~clearMask;
        missileHit_d = 1'b0;
        playerHit_d  = 1'b0;
        overrun_d    = 1'b0;
        if (startOfFrame) begin
            acc_d        = '0;
            playerAcc_d  = 1'b0;
            pending_d    = pending_d | accEff;
            missileHit_d = |accEff;
            playerHit_d  = playerEff;
            overrun_d    = |pending_q;
        end
    end

    lowest_set_index #(
        .W (N_ENEMIES),
        .IW(IDX_W)
    ) u_lowest (
        .vec_i  (pending_d),
        .index_o(nextIndex),
        .any_o  (pendingAny)
    );

    // Reporting FSM and registered stream outputs; an unaccepted index is held steady
    // even if a snapshot adds a lower-numbered hit.
    always_comb begin
        state_d    = state_q;
        hitIndex_d = '0;
        if (state_q == IDLE) begin
            if (pendingAny) begin
                state_d = REPORT;
            end
        end else begin
            if (!pendingAny) begin
                state_d = IDLE;
            end
        end
        hitValid_d = (state_d == REPORT);
        if (hitValid_q && !hit_ready) begin
            hitIndex_d = hitIndex_q;
        end else if (pendingAny) begin
            hitIndex_d = nextIndex;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            playerAcc_q  <= 1'b0;
            pending_q    <= '0;
            hitValid_q   <= 1'b0;
            hitIndex_q   <= '0;
            missileHit_q <= 1'b0;
            playerHit_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            playerAcc_q  <= playerAcc_d;
            pending_q    <= pending_d;
            hitValid_q   <= hitValid_d;
            hitIndex_q   <= hitIndex_d;
            missileHit_q <= missileHit_d;
            playerHit_q  <= playerHit_d;
            overrun_q    <= overrun_d;
        end
    end

    assign hit_valid     = hitValid_q;
    assign hit_index     = hitIndex_q;
    assign missile_hit   = missileHit_q;
    assign player_hit    = playerHit_q;
    assign frame_overrun = overrun_q;

`ifdef HIT_STATS_EN
    logic [15:0] hitTotal_q, hitTotal_d;

    // Count accepted hits, sticking at the maximum instead of wrapping.
    always_comb begin
        hitTotal_d = hitTotal_q;
        if (accept && (hitTotal_q != 16'hFFFF)) begin
            hitTotal_d = hitTotal_q + 16'd1;
        end
    end

    // Hit counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hitTotal_q <= '0;
        end else begin
            hitTotal_q <= hitTotal_d;
        end
    end

    assign hit_total = hitTotal_q;
`endif

endmodule
